// File: rtl/rec_time_pkg.sv
// Shared control codes, event field layout, mode/state enums for the recorder time base.
package rec_time_pkg;

  localparam logic [3:0] REC_RECORD = 4'd1;
  localparam logic [3:0] REC_PAUSE  = 4'd2;
  localparam logic [3:0] REC_STOP   = 4'd3;
  localparam logic [3:0] REC_PLAY   = 4'd4;

  localparam int EV_CODE_LO = 12;
  localparam int EV_MODE_LO = 10;
  localparam int EV_SPD_LO  = 6;

  typedef enum logic [1:0] {NORMAL, SLOW, FAST} mode_t;

  typedef enum logic [2:0] {
    ST_IDLE, ST_RECORD, ST_REC_PAUSE, ST_PLAY, ST_PLAY_PAUSE, ST_STOP
  } state_t;

  function automatic mode_t decode_mode(input logic [1:0] m);
    case (m)
      2'b10:   return FAST;
      2'b01:   return SLOW;
      default: return NORMAL;
    endcase
  endfunction

endpackage

// File: rtl/bcd_time_counter.sv
// BCD mm..m:ss counter with clear, load and optional saturation at all-9 minutes:59.
module bcd_time_counter #(
  parameter int MIN_DIGITS = 2
) (
  input  logic                        i_clk,
  input  logic                        i_rst,
  input  logic                        inc_sec,
  input  logic                        clr,
  input  logic                        load,
  input  logic [4*(MIN_DIGITS+2)-1:0] load_val,
  input  logic                        sat_en,
  output logic [4*(MIN_DIGITS+2)-1:0] digits,
  output logic [4*(MIN_DIGITS+2)-1:0] next_digits,
  output logic                        full
);

  localparam int W = 4*(MIN_DIGITS+2);
  localparam logic [W-1:0] MAX_VAL = {{MIN_DIGITS{4'h9}}, 8'h59};

  logic [W-1:0] nxt;
  logic         cy;
  logic         at_max;

  assign at_max = (digits == MAX_VAL);

  // Ripple the +1 second through all digits in one pass; digit 1 is tens-of-seconds (wraps at 5).
  always_comb begin
    nxt = digits;
    cy  = 1'b1;
    for (int i = 0; i < MIN_DIGITS+2; i++) begin
      if (cy) begin
        if (digits[4*i +: 4] == ((i == 1) ? 4'd5 : 4'd9)) begin
          nxt[4*i +: 4] = 4'd0;
        end else begin
          nxt[4*i +: 4] = digits[4*i +: 4] + 4'd1;
          cy            = 1'b0;
        end
      end
    end
  end

  assign next_digits = (sat_en && at_max) ? digits : nxt;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      digits <= '0;
      full   <= 1'b0;
    end else if (clr) begin
      digits <= '0;
      full   <= 1'b0;
    end else if (load) begin
      digits <= load_val;
    end else if (inc_sec) begin
      if (sat_en && at_max) full   <= 1'b1;
      else                  digits <= nxt;
    end
  end

endmodule

// File: rtl/rec_time_tracker.sv
// Recorder/player time base: decodes control events, runs record and play BCD clocks
// with fractional-remainder second ticks and fast/slow play rates.
module rec_time_tracker
  import rec_time_pkg::*;
#(
  parameter int CLK_FREQ   = 50000000,
  parameter int MIN_DIGITS = 2,
  parameter int MAX_SPEED  = 8
) (
  input  logic                        i_clk,
  input  logic                        i_rst,
  input  logic [15:0]                 i_input_event,
  output logic [4*(MIN_DIGITS+2)-1:0] o_record_time,
  output logic [4*(MIN_DIGITS+2)-1:0] o_play_time,
  output logic [2:0]                  o_state,
  output logic                        o_rec_full,
  output logic                        o_play_done
);

  localparam int W     = 4*(MIN_DIGITS+2);
  localparam int SUB_W = $clog2(CLK_FREQ+MAX_SPEED);

  state_t           state, nstate;
  logic [SUB_W-1:0] sub, inc, sum;
  logic [3:0]       div, code, spd;
  mode_t            mode;
  logic             spd_ok, div_hit, ev_hit, rec_clr, play_clr;
  logic             rec_run, play_run, tick, play_end;
  logic [W-1:0]     play_nxt, rec_nxt;
  logic             play_full;

  assign code    = i_input_event[EV_CODE_LO +: 4];
  assign mode    = decode_mode(i_input_event[EV_MODE_LO +: 2]);
  assign spd     = i_input_event[EV_SPD_LO +: 4];
  assign spd_ok  = (spd >= 4'd2) && (spd <= 4'(MAX_SPEED));
  assign div_hit = (div >= spd - 4'd1);

  always_comb begin
    nstate   = state;
    ev_hit   = 1'b0;
    rec_clr  = 1'b0;
    play_clr = 1'b0;
    case (code)
      REC_RECORD:
        if (state == ST_IDLE || state == ST_STOP) begin
          nstate = ST_RECORD; ev_hit = 1'b1; rec_clr = 1'b1;
        end else if (state == ST_REC_PAUSE) begin
          nstate = ST_RECORD; ev_hit = 1'b1;
        end
      REC_PAUSE:
        if (state == ST_RECORD) begin
          nstate = ST_REC_PAUSE; ev_hit = 1'b1;
        end else if (state == ST_PLAY) begin
          nstate = ST_PLAY_PAUSE; ev_hit = 1'b1;
        end
      REC_PLAY:
        if ((state == ST_IDLE || state == ST_STOP) && o_record_time != '0) begin
          nstate = ST_PLAY; ev_hit = 1'b1; play_clr = 1'b1;
        end else if (state == ST_PLAY_PAUSE) begin
          nstate = ST_PLAY; ev_hit = 1'b1;
        end
      REC_STOP:
        if (state != ST_IDLE) begin
          nstate = ST_STOP; ev_hit = 1'b1; play_clr = 1'b1;
        end
      default: ;
    endcase
  end

  // An accepted event pre-empts counting for that cycle.
  assign rec_run  = (state == ST_RECORD) && !ev_hit;
  assign play_run = (state == ST_PLAY) && !ev_hit;

  always_comb begin
    inc = '0;
    if (rec_run) begin
      inc = SUB_W'(1);
    end else if (play_run) begin
      case (mode)
        FAST:    inc = spd_ok ? SUB_W'(spd) : SUB_W'(1);
        SLOW:    inc = (!spd_ok || div_hit) ? SUB_W'(1) : '0;
        default: inc = SUB_W'(1);
      endcase
    end
  end

  assign sum      = sub + inc;
  assign tick     = (rec_run || play_run) && (sum >= SUB_W'(CLK_FREQ));
  assign play_end = play_run && tick && ((play_nxt >= o_record_time) || play_full);

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state       <= ST_IDLE;
      sub         <= '0;
      div         <= '0;
      o_play_done <= 1'b0;
    end else begin
      state       <= play_end ? ST_STOP : nstate;
      o_play_done <= play_end;
      if (rec_clr || play_clr) begin
        sub <= '0;
        div <= '0;
      end else begin
        if (rec_run || play_run) sub <= tick ? sum - SUB_W'(CLK_FREQ) : sum;
        if (play_run && mode == SLOW && spd_ok) div <= div_hit ? 4'd0 : div + 4'd1;
      end
    end
  end

  assign o_state = state;

  bcd_time_counter #(.MIN_DIGITS(MIN_DIGITS)) u_rec (
    .i_clk       (i_clk),
    .i_rst       (i_rst),
    .inc_sec     (rec_run && tick),
    .clr         (rec_clr),
    .load        (1'b0),
    .load_val    ('0),
    .sat_en      (1'b1),
    .digits      (o_record_time),
    .next_digits (rec_nxt),
    .full        (o_rec_full)
  );

  // Play end loads the record time so the display lands exactly on it.
  bcd_time_counter #(.MIN_DIGITS(MIN_DIGITS)) u_play (
    .i_clk       (i_clk),
    .i_rst       (i_rst),
    .inc_sec     (play_run && tick),
    .clr         (play_clr),
    .load        (play_end),
    .load_val    (o_record_time),
    .sat_en      (1'b1),
    .digits      (o_play_time),
    .next_digits (play_nxt),
    .full        (play_full)
  );

  logic unused_rec_nxt;
  assign unused_rec_nxt = ^rec_nxt;

endmodule

// File: tb/tb_rec_time_tracker.sv
// Directed table-driven bench for rec_time_tracker, plus saturation and reset sequences.
module tb_rec_time_tracker;
  import rec_time_pkg::*;

  localparam logic [1:0] M_NORM = 2'b00;
  localparam logic [1:0] M_SLOW = 2'b01;
  localparam logic [1:0] M_FAST = 2'b10;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] ev, ev2;
  logic [15:0] rec_t, play_t;
  logic [2:0]  st;
  logic        full, done;
  logic [11:0] rec2, play2;
  logic [2:0]  st2;
  logic        full2, done2;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  rec_time_tracker #(.CLK_FREQ(10), .MIN_DIGITS(2), .MAX_SPEED(8)) dut (
    .i_clk(clk), .i_rst(rst), .i_input_event(ev),
    .o_record_time(rec_t), .o_play_time(play_t), .o_state(st),
    .o_rec_full(full), .o_play_done(done)
  );

  rec_time_tracker #(.CLK_FREQ(4), .MIN_DIGITS(1), .MAX_SPEED(2)) dut_sat (
    .i_clk(clk), .i_rst(rst), .i_input_event(ev2),
    .o_record_time(rec2), .o_play_time(play2), .o_state(st2),
    .o_rec_full(full2), .o_play_done(done2)
  );

  typedef struct {
    logic [3:0]  code;
    logic [1:0]  mode;
    logic [3:0]  spd;
    int          n;
    logic [15:0] rec;
    logic [15:0] play;
    logic [2:0]  st;
    logic        done;
  } vec_t;

  vec_t vecs[20];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", name, got, exp);
    end
  endtask

  // Event (if any) for one edge, then n idle edges with mode/speed held; returns at a negedge.
  task automatic apply(input logic [3:0] c, input logic [1:0] m, input logic [3:0] s, input int n);
    if (c != 4'd0) begin
      ev = {c, m, s, 6'd0};
      @(negedge clk);
    end
    ev = {4'd0, m, s, 6'd0};
    repeat (n) @(negedge clk);
  endtask

  initial begin
    vecs[0]  = '{REC_RECORD, M_NORM, 4'd0,  30, 16'h0003, 16'h0000, ST_RECORD,     1'b0};
    vecs[1]  = '{REC_STOP,   M_NORM, 4'd0,   5, 16'h0003, 16'h0000, ST_STOP,       1'b0};
    vecs[2]  = '{REC_RECORD, M_NORM, 4'd0, 590, 16'h0059, 16'h0000, ST_RECORD,     1'b0};
    vecs[3]  = '{4'd0,       M_NORM, 4'd0,  10, 16'h0100, 16'h0000, ST_RECORD,     1'b0};
    vecs[4]  = '{REC_STOP,   M_NORM, 4'd0,   0, 16'h0100, 16'h0000, ST_STOP,       1'b0};
    vecs[5]  = '{REC_RECORD, M_NORM, 4'd0,  45, 16'h0004, 16'h0000, ST_RECORD,     1'b0};
    vecs[6]  = '{REC_PAUSE,  M_NORM, 4'd0, 100, 16'h0004, 16'h0000, ST_REC_PAUSE,  1'b0};
    vecs[7]  = '{REC_RECORD, M_NORM, 4'd0,  55, 16'h0010, 16'h0000, ST_RECORD,     1'b0};
    vecs[8]  = '{4'd0,       M_NORM, 4'd0, 100, 16'h0020, 16'h0000, ST_RECORD,     1'b0};
    vecs[9]  = '{REC_STOP,   M_NORM, 4'd0,   0, 16'h0020, 16'h0000, ST_STOP,       1'b0};
    vecs[10] = '{4'd7,       M_NORM, 4'd0,   3, 16'h0020, 16'h0000, ST_STOP,       1'b0};
    vecs[11] = '{REC_PLAY,   M_FAST, 4'd4,  25, 16'h0020, 16'h0010, ST_PLAY,       1'b0};
    vecs[12] = '{4'd0,       M_FAST, 4'd4,  24, 16'h0020, 16'h0019, ST_PLAY,       1'b0};
    vecs[13] = '{4'd0,       M_FAST, 4'd4,   1, 16'h0020, 16'h0020, ST_STOP,       1'b1};
    vecs[14] = '{4'd0,       M_FAST, 4'd4,   1, 16'h0020, 16'h0020, ST_STOP,       1'b0};
    vecs[15] = '{REC_PLAY,   M_SLOW, 4'd3,  30, 16'h0020, 16'h0001, ST_PLAY,       1'b0};
    vecs[16] = '{REC_PAUSE,  M_SLOW, 4'd3,  40, 16'h0020, 16'h0001, ST_PLAY_PAUSE, 1'b0};
    vecs[17] = '{REC_PLAY,   M_SLOW, 4'd3,  30, 16'h0020, 16'h0002, ST_PLAY,       1'b0};
    vecs[18] = '{4'd0,       M_SLOW, 4'd9,  10, 16'h0020, 16'h0003, ST_PLAY,       1'b0};
    vecs[19] = '{REC_STOP,   M_NORM, 4'd0,   0, 16'h0020, 16'h0000, ST_STOP,       1'b0};

    rst = 1'b1; ev = '0; ev2 = '0;
    repeat (2) @(negedge clk);
    chk("rst_rec", 32'(rec_t), 32'h0);
    chk("rst_play", 32'(play_t), 32'h0);
    chk("rst_state", 32'(st), 32'(ST_IDLE));
    chk("rst_full", 32'(full), 32'h0);
    chk("rst_done", 32'(done), 32'h0);
    rst = 1'b0;
    @(negedge clk);
    apply(REC_STOP, M_NORM, 4'd0, 2);
    chk("stop_in_idle", 32'(st), 32'(ST_IDLE));

    // Saturation on the small instance: 9:59 after 599 s at 4 cycles/s.
    ev2 = {REC_RECORD, 12'd0};
    @(negedge clk);
    ev2 = '0;
    repeat (2396) @(negedge clk);
    chk("sat_reach_time", 32'(rec2), 32'h959);
    chk("sat_reach_full", 32'(full2), 32'h0);
    repeat (10) @(negedge clk);
    chk("sat_hold_time", 32'(rec2), 32'h959);
    chk("sat_full", 32'(full2), 32'h1);
    chk("sat_state", 32'(st2), 32'(ST_RECORD));

    for (int i = 0; i < 20; i++) begin
      apply(vecs[i].code, vecs[i].mode, vecs[i].spd, vecs[i].n);
      chk($sformatf("v%0d_rec", i), 32'(rec_t), 32'(vecs[i].rec));
      chk($sformatf("v%0d_play", i), 32'(play_t), 32'(vecs[i].play));
      chk($sformatf("v%0d_state", i), 32'(st), 32'(vecs[i].st));
      chk($sformatf("v%0d_done", i), 32'(done), 32'(vecs[i].done));
      chk($sformatf("v%0d_full", i), 32'(full), 32'h0);
    end

    // Asynchronous reset in the middle of playback.
    apply(REC_PLAY, M_NORM, 4'd0, 15);
    chk("pre_rst_play", 32'(play_t), 32'h0001);
    rst = 1'b1;
    #1;
    chk("mid_rst_rec", 32'(rec_t), 32'h0);
    chk("mid_rst_play", 32'(play_t), 32'h0);
    chk("mid_rst_state", 32'(st), 32'(ST_IDLE));
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    apply(REC_PLAY, M_NORM, 4'd0, 5);
    chk("play_empty_state", 32'(st), 32'(ST_IDLE));
    chk("play_empty_time", 32'(play_t), 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
